ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle, parametrised control unit for the A/B accumulator datapath. Replaces purely combinational opcode decoding with a FETCH/EXEC/MEM/HALT state machine. Adds instruction-fetch and data-memory handshakes, flag-conditional jumps via `LP`, status-register load, illegal-opcode detection, halt, and a retired-instruction counter. Sits between the instruction memory (opcode source) and the register file, ALU and data memory.

## Interface
- `OPCODE_W`, 7: opcode width.
- `STATUS_W`, 4: status width. Bit mapping: [0]=Z, [1]=N, [2]=C, [3]=V.
- `ALU_OP_W`, 4: ALU operation field width.
- `CNT_W`, 16: retired-instruction counter width.

Ports (clock and reset first):
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in OPCODE_W: opcode from instruction memory.
- `instr_valid` in 1: `opcode` is valid this cycle.
- `status` in STATUS_W: current flags from the status register.
- `mem_ready` in 1: data memory completes the access this cycle.
- `ir_load` out 1: opcode is latched into the internal IR this cycle.
- `pc_inc` out 1: increment PC.
- `LA`, `LB` out 1: load register A / register B.
- `LP` out 1: load PC from K (jump taken).
- `LS` out 1: load the status register from the ALU flags.
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: write access (valid only with `mem_req`).
- `wbSel` out 1: write-back source. 0 = ALU, 1 = memory.
- `selA` out 2: 00=A, 01=B, 10=0, 11=1.
- `selB` out 2: 00=B, 01=A, 10=K, 11=0.
- `selData` out 2: memory address source. 00=A, 01=B, 10=K.
- `alu_op` out ALU_OP_W: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0111 SHL, 1000 SHR.
- `illegal` out 1: one-cycle pulse for an unknown opcode.
- `halted` out 1: held high in HALT.
- `retired` out CNT_W: count of retired instructions.

## Operation
- **Decoded opcodes:**
  - MOV A,B 0000000; MOV B,A 0000001; MOV A,K 0000010; MOV B,K 0000011.
  - ADD A,B 0000100; ADD B,A 0000101; SUB A,B 0001000; AND A,K 0001110; OR B,A 0010001.
  - SHL A 0011100; SHR B 0100011; INC B 0100100.
  - LD A,(addr) 0101000; ST (addr),A 0101010.
  - CMP A,B 1001101: SUB with `LS` only, no register load.
  - JMP 1010011; JEQ 1010100 (Z=1); JNE 1010101 (Z=0); JCS 1010110 (C=1); JMI 1010111 (N=1).
  - HALT 1111111.
- **Arithmetic and logic ops** also assert `LS` in EXEC. MOV does not assert `LS`.
- **Control outputs** are a function of state and the latched IR. They are zero outside the cycle in which they are listed below.
- **FETCH:**
  - `ir_load` = `instr_valid`.
  - If `instr_valid`: latch IR, go to EXEC. Otherwise stay in FETCH.
- **EXEC, register/ALU op:**
  - Assert that op's load, selects and `alu_op`, plus `pc_inc`.
  - `retired`++. Go to FETCH.
- **EXEC, jump:**
  - Condition is evaluated on `status` in this cycle.
  - Taken: `LP`=1, `pc_inc`=0. Not taken: `pc_inc`=1, `LP`=0. Never both.
  - `retired`++. Go to FETCH.
- **EXEC, LD/ST:** go to MEM. No outputs asserted in this cycle.
- **MEM:**
  - `mem_req`=1 and `selData` held every cycle until `mem_ready`.
  - ST: `mem_we`=1, `selData`=01.
  - LD: `selData`=00. In the `mem_ready` cycle only, also `LA`=1 and `wbSel`=1.
  - On `mem_ready`: `pc_inc`=1, `retired`++, go to FETCH.
- **EXEC, illegal opcode:** `illegal`=1 for one cycle, `pc_inc`=1, no loads, `retired` unchanged, go to FETCH.
- **EXEC, HALT:** go to HALT.
- **HALT:**
  - `halted`=1, all other outputs 0.
  - `instr_valid` is ignored and `retired` is frozen.
  - HALT is exited only by reset.
- **Counter:** `retired` wraps modulo 2^CNT_W.

## Timing
- **Reset (async):** state=FETCH, IR=0, `retired`=0, and every output 0 immediately while `rst_n`=0.
- **Reset mid-operation:** reset during MEM or HALT aborts the access. `mem_req` drops without waiting for the rising edge.
- **Latency:**
  - Register, ALU and jump instructions: 2 cycles (FETCH, EXEC), given `instr_valid` is already high.
  - LD/ST: 3 + wait cycles.
- **`mem_ready` outside MEM** is ignored.
- **`status` changing in the same cycle as a jump:** the value sampled in the EXEC cycle governs the jump.
- **Outputs are glitch-relevant only at the clock edge.** Consumers sample them on the rising edge.

## Structure
- **Package `ctrl_pkg`:**
  - State enum: FETCH, EXEC, MEM, HALT.
  - Opcode constants.
  - `alu_op` constants.
  - `selA`, `selB` and `selData` encodings.
  - Status bit indices.
- **Sub-module `ctrl_decode`:** combinational IR → control word, plus class flags (is_mem, is_jump, is_illegal, is_halt). `ctrl_fsm` instantiates it and gates its outputs by state.

## Test plan
- **MOV A,K:** `opcode`=0000010 with `instr_valid`=1.
  - Cycle 1: `ir_load`=1.
  - Cycle 2: `LA`=1, `selA`=10, `selB`=10, `alu_op`=0000, `pc_inc`=1, `LS`=0.
  - `retired`=1.
- **LD with wait:** `opcode`=0101000, `mem_ready` low for 3 cycles.
  - `mem_req`=1 for 4 cycles with `selData`=00.
  - `LA`, `wbSel` and `pc_inc` high only in the 4th cycle.
- **Jumps:**
  - JEQ with `status`=0001: `LP`=1, `pc_inc`=0.
  - JEQ with `status`=0000: `LP`=0, `pc_inc`=1.
  - JCS with `status`=0100: `LP`=1.
- **Illegal opcode 1100000:** `illegal` is a one-cycle pulse, no `LA`/`LB`/`LS`, `pc_inc`=1, `retired` unchanged.
- **HALT then reset:**
  - `halted` stays 1 for 10 cycles while `instr_valid`=1, and `retired` is frozen.
  - Pulse `rst_n` low during an ST in MEM: `mem_req` drops immediately, state returns to FETCH, `retired`=0.
- **Counter wrap (CNT_W=4):** 16 ADD A,B instructions give `retired`=0. CMP A,B asserts `LS`=1 with `LA`=`LB`=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the A/B accumulator control unit.
// Covers state codes, opcodes, ALU ops, operand selects, status bit indices and the decoded control word.
package ctrl_pkg;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [6:0] OP_MOV_AB = 7'b0000000;
    localparam logic [6:0] OP_MOV_BA = 7'b0000001;
    localparam logic [6:0] OP_MOV_AK = 7'b0000010;
    localparam logic [6:0] OP_MOV_BK = 7'b0000011;
    localparam logic [6:0] OP_ADD_AB = 7'b0000100;
    localparam logic [6:0] OP_ADD_BA = 7'b0000101;
    localparam logic [6:0] OP_SUB_AB = 7'b0001000;
    localparam logic [6:0] OP_AND_AK = 7'b0001110;
    localparam logic [6:0] OP_OR_BA  = 7'b0010001;
    localparam logic [6:0] OP_SHL_A  = 7'b0011100;
    localparam logic [6:0] OP_SHR_B  = 7'b0100011;
    localparam logic [6:0] OP_INC_B  = 7'b0100100;
    localparam logic [6:0] OP_LD_A   = 7'b0101000;
    localparam logic [6:0] OP_ST_A   = 7'b0101010;
    localparam logic [6:0] OP_CMP_AB = 7'b1001101;
    localparam logic [6:0] OP_JMP    = 7'b1010011;
    localparam logic [6:0] OP_JEQ    = 7'b1010100;
    localparam logic [6:0] OP_JNE    = 7'b1010101;
    localparam logic [6:0] OP_JCS    = 7'b1010110;
    localparam logic [6:0] OP_JMI    = 7'b1010111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SHL = 4'b0111;
    localparam logic [3:0] ALU_SHR = 4'b1000;

    localparam logic [1:0] SELA_A    = 2'b00;
    localparam logic [1:0] SELA_B    = 2'b01;
    localparam logic [1:0] SELA_ZERO = 2'b10;
    localparam logic [1:0] SELA_ONE  = 2'b11;

    localparam logic [1:0] SELB_B    = 2'b00;
    localparam logic [1:0] SELB_A    = 2'b01;
    localparam logic [1:0] SELB_K    = 2'b10;
    localparam logic [1:0] SELB_ZERO = 2'b11;

    localparam logic [1:0] SELD_A = 2'b00;
    localparam logic [1:0] SELD_B = 2'b01;
    localparam logic [1:0] SELD_K = 2'b10;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    typedef enum logic [2:0] {
        JC_ALWAYS,
        JC_Z,
        JC_NZ,
        JC_C,
        JC_N
    } jcond_e;

    typedef struct packed {
        logic       la;
        logic       lb;
        logic       ls;
        logic       mem_we;
        logic       wb_sel;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic [1:0] sel_data;
        logic [3:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: IR to control word and instruction class flags.
// Latency: combinational.
// Backpressure: none; the FSM decides when the decoded word is used.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] ir,
    output ctrl_word_t          cw,
    output jcond_e              jcond,
    output logic                is_mem,
    output logic                is_jump,
    output logic                is_illegal,
    output logic                is_halt
);

    always_comb begin
        cw         = '0;
        jcond      = JC_ALWAYS;
        is_mem     = 1'b0;
        is_jump    = 1'b0;
        is_illegal = 1'b0;
        is_halt    = 1'b0;
        case (ir)
            // MOVs route the source through ALU ADD with a zero operand
            OPCODE_W'(OP_MOV_AB): begin cw.la = 1'b1; cw.sel_a = SELA_ZERO; cw.sel_b = SELB_B; end
            OPCODE_W'(OP_MOV_BA): begin cw.lb = 1'b1; cw.sel_a = SELA_ZERO; cw.sel_b = SELB_A; end
            OPCODE_W'(OP_MOV_AK): begin cw.la = 1'b1; cw.sel_a = SELA_ZERO; cw.sel_b = SELB_K; end
            OPCODE_W'(OP_MOV_BK): begin cw.lb = 1'b1; cw.sel_a = SELA_ZERO; cw.sel_b = SELB_K; end
            OPCODE_W'(OP_ADD_AB): begin cw.la = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_A; cw.sel_b = SELB_B; cw.alu_op = ALU_ADD; end
            OPCODE_W'(OP_ADD_BA): begin cw.lb = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_B; cw.sel_b = SELB_A; cw.alu_op = ALU_ADD; end
            OPCODE_W'(OP_SUB_AB): begin cw.la = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_A; cw.sel_b = SELB_B; cw.alu_op = ALU_SUB; end
            OPCODE_W'(OP_AND_AK): begin cw.la = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_A; cw.sel_b = SELB_K; cw.alu_op = ALU_AND; end
            OPCODE_W'(OP_OR_BA):  begin cw.lb = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_B; cw.sel_b = SELB_A; cw.alu_op = ALU_OR; end
            OPCODE_W'(OP_SHL_A):  begin cw.la = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_A; cw.sel_b = SELB_ZERO; cw.alu_op = ALU_SHL; end
            OPCODE_W'(OP_SHR_B):  begin cw.lb = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_B; cw.sel_b = SELB_ZERO; cw.alu_op = ALU_SHR; end
            OPCODE_W'(OP_INC_B):  begin cw.lb = 1'b1; cw.ls = 1'b1; cw.sel_a = SELA_ONE; cw.sel_b = SELB_B; cw.alu_op = ALU_ADD; end
            OPCODE_W'(OP_CMP_AB): begin cw.ls = 1'b1; cw.sel_a = SELA_A; cw.sel_b = SELB_B; cw.alu_op = ALU_SUB; end
            OPCODE_W'(OP_LD_A):   begin is_mem = 1'b1; cw.la = 1'b1; cw.wb_sel = 1'b1; cw.sel_data = SELD_A; end
            OPCODE_W'(OP_ST_A):   begin is_mem = 1'b1; cw.mem_we = 1'b1; cw.sel_data = SELD_B; end
            OPCODE_W'(OP_JMP):    begin is_jump = 1'b1; jcond = JC_ALWAYS; end
            OPCODE_W'(OP_JEQ):    begin is_jump = 1'b1; jcond = JC_Z; end
            OPCODE_W'(OP_JNE):    begin is_jump = 1'b1; jcond = JC_NZ; end
            OPCODE_W'(OP_JCS):    begin is_jump = 1'b1; jcond = JC_C; end
            OPCODE_W'(OP_JMI):    begin is_jump = 1'b1; jcond = JC_N; end
            OPCODE_W'(OP_HALT):   is_halt = 1'b1;
            default:              is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Purpose: FETCH/EXEC/MEM/HALT control unit for the A/B accumulator datapath.
// Latency: 2 cycles for register/ALU/jump, 3 + wait cycles for LD/ST.
// Backpressure: stalls in FETCH until instr_valid, in MEM until mem_ready.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int STATUS_W = 4,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic [STATUS_W-1:0] status,
    input  logic                mem_ready,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                LA,
    output logic                LB,
    output logic                LP,
    output logic                LS,
    output logic                mem_req,
    output logic                mem_we,
    output logic                wbSel,
    output logic [1:0]          selA,
    output logic [1:0]          selB,
    output logic [1:0]          selData,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [OPCODE_W-1:0] ir;
    logic                retire;
    logic                jmp_taken;
    ctrl_word_t          cw;
    jcond_e              jcond;
    logic                is_mem;
    logic                is_jump;
    logic                is_illegal;
    logic                is_halt;
    logic                status_unused;

    assign status_unused = ^status[STATUS_W-1:ST_V];

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .ir         (ir),
        .cw         (cw),
        .jcond      (jcond),
        .is_mem     (is_mem),
        .is_jump    (is_jump),
        .is_illegal (is_illegal),
        .is_halt    (is_halt)
    );

    always_comb begin
        case (jcond)
            JC_Z:    jmp_taken = status[ST_Z];
            JC_NZ:   jmp_taken = ~status[ST_Z];
            JC_C:    jmp_taken = status[ST_C];
            JC_N:    jmp_taken = status[ST_N];
            default: jmp_taken = 1'b1;
        endcase
    end

    // Outputs are forced low while rst_n is asserted so an aborted access drops at once
    always_comb begin
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        LA        = 1'b0;
        LB        = 1'b0;
        LP        = 1'b0;
        LS        = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        wbSel     = 1'b0;
        selA      = 2'b00;
        selB      = 2'b00;
        selData   = 2'b00;
        alu_op    = '0;
        illegal   = 1'b0;
        halted    = 1'b0;
        retire    = 1'b0;
        state_nxt = state;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    ir_load = instr_valid;
                    if (instr_valid) state_nxt = S_EXEC;
                end
                S_EXEC: begin
                    state_nxt = S_FETCH;
                    if (is_halt) begin
                        state_nxt = S_HALT;
                    end else if (is_mem) begin
                        state_nxt = S_MEM;
                    end else if (is_illegal) begin
                        illegal = 1'b1;
                        pc_inc  = 1'b1;
                    end else if (is_jump) begin
                        LP     = jmp_taken;
                        pc_inc = ~jmp_taken;
                        retire = 1'b1;
                    end else begin
                        LA     = cw.la;
                        LB     = cw.lb;
                        LS     = cw.ls;
                        selA   = cw.sel_a;
                        selB   = cw.sel_b;
                        alu_op = ALU_OP_W'(cw.alu_op);
                        pc_inc = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = cw.mem_we;
                    selData = cw.sel_data;
                    if (mem_ready) begin
                        LA        = cw.la;
                        wbSel     = cw.wb_sel;
                        pc_inc    = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) ir <= opcode;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: stimulus pushes per-cycle expected outputs, a monitor compares on the falling edge.
module tb_ctrl_fsm;

    localparam logic [6:0] OP_MOV_BA = 7'b0000001;
    localparam logic [6:0] OP_MOV_AK = 7'b0000010;
    localparam logic [6:0] OP_ADD_AB = 7'b0000100;
    localparam logic [6:0] OP_AND_AK = 7'b0001110;
    localparam logic [6:0] OP_OR_BA  = 7'b0010001;
    localparam logic [6:0] OP_SHR_B  = 7'b0100011;
    localparam logic [6:0] OP_INC_B  = 7'b0100100;
    localparam logic [6:0] OP_LD_A   = 7'b0101000;
    localparam logic [6:0] OP_ST_A   = 7'b0101010;
    localparam logic [6:0] OP_CMP_AB = 7'b1001101;
    localparam logic [6:0] OP_JMP    = 7'b1010011;
    localparam logic [6:0] OP_JEQ    = 7'b1010100;
    localparam logic [6:0] OP_JNE    = 7'b1010101;
    localparam logic [6:0] OP_JCS    = 7'b1010110;
    localparam logic [6:0] OP_JMI    = 7'b1010111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;
    localparam logic [6:0] OP_BAD    = 7'b1100000;

    typedef struct packed {
        logic       ir_load;
        logic       pc_inc;
        logic       la;
        logic       lb;
        logic       lp;
        logic       ls;
        logic       mem_req;
        logic       mem_we;
        logic       wb_sel;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic [1:0] sel_data;
        logic [3:0] alu_op;
        logic       illegal;
        logic       halted;
        logic [3:0] retired;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       instr_valid;
    logic [3:0] status;
    logic       mem_ready;
    logic       ir_load, pc_inc, LA, LB, LP, LS, mem_req, mem_we, wbSel, illegal, halted;
    logic [1:0] selA, selB, selData;
    logic [3:0] alu_op;
    logic [3:0] retired;

    obs_t  obs;
    obs_t  exp_q[$];
    string name_q[$];
    obs_t  m_exp;
    string m_name;
    int    n_tests;
    int    n_fail;

    ctrl_fsm #(.OPCODE_W(7), .STATUS_W(4), .ALU_OP_W(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .status      (status),
        .mem_ready   (mem_ready),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .LA          (LA),
        .LB          (LB),
        .LP          (LP),
        .LS          (LS),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .wbSel       (wbSel),
        .selA        (selA),
        .selB        (selB),
        .selData     (selData),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .halted      (halted),
        .retired     (retired)
    );

    assign obs = {ir_load, pc_inc, LA, LB, LP, LS, mem_req, mem_we, wbSel,
                  selA, selB, selData, alu_op, illegal, halted, retired};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t f_zero(input logic [3:0] r);
        obs_t o;
        o = '0;
        o.retired = r;
        return o;
    endfunction

    function automatic obs_t f_fetch(input logic [3:0] r);
        obs_t o = f_zero(r);
        o.ir_load = 1'b1;
        return o;
    endfunction

    function automatic obs_t f_alu(input logic la, input logic lb, input logic ls, input logic [1:0] sa,
                                   input logic [1:0] sb, input logic [3:0] op, input logic [3:0] r);
        obs_t o = f_zero(r);
        o.pc_inc = 1'b1;
        o.la = la;
        o.lb = lb;
        o.ls = ls;
        o.sel_a = sa;
        o.sel_b = sb;
        o.alu_op = op;
        return o;
    endfunction

    function automatic obs_t f_jmp(input logic lp, input logic pc, input logic [3:0] r);
        obs_t o = f_zero(r);
        o.lp = lp;
        o.pc_inc = pc;
        return o;
    endfunction

    function automatic obs_t f_mem(input logic we, input logic [1:0] sd, input logic la, input logic wb,
                                   input logic pc, input logic [3:0] r);
        obs_t o = f_zero(r);
        o.mem_req = 1'b1;
        o.mem_we = we;
        o.sel_data = sd;
        o.la = la;
        o.wb_sel = wb;
        o.pc_inc = pc;
        return o;
    endfunction

    function automatic obs_t f_ill(input logic [3:0] r);
        obs_t o = f_zero(r);
        o.illegal = 1'b1;
        o.pc_inc = 1'b1;
        return o;
    endfunction

    function automatic obs_t f_halt(input logic [3:0] r);
        obs_t o = f_zero(r);
        o.halted = 1'b1;
        return o;
    endfunction

    task automatic step(input logic rn, input logic iv, input logic [6:0] op, input logic [3:0] st,
                        input logic mr, input obs_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n       = rn;
        instr_valid = iv;
        opcode      = op;
        status      = st;
        mem_ready   = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // FETCH cycle followed by an EXEC cycle
    task automatic run2(input logic [6:0] op, input logic [3:0] st_f, input logic [3:0] st_e,
                        input obs_t e_exec, input logic [3:0] r, input string nm);
        step(1'b1, 1'b1, op, st_f, 1'b0, f_fetch(r), {nm, "_fetch"});
        step(1'b1, 1'b0, op, st_e, 1'b0, e_exec, {nm, "_exec"});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL %s: outputs %b, required %b", m_name, obs, m_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 7'd0;
        status      = 4'd0;
        mem_ready   = 1'b0;

        // Reset holds every output low even with instr_valid high
        step(1'b0, 1'b1, OP_MOV_AK, 4'b0000, 1'b1, f_zero(4'd0), "reset_state");
        step(1'b0, 1'b1, OP_MOV_AK, 4'b0000, 1'b0, f_zero(4'd0), "reset_hold");

        run2(OP_MOV_AK, 4'b0000, 4'b0000, f_alu(1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 4'b0000, 4'd0), 4'd0, "mov_ak");

        // LD: mem_ready in EXEC is ignored, then three wait cycles in MEM
        step(1'b1, 1'b1, OP_LD_A, 4'b0000, 1'b0, f_fetch(4'd1), "ld_fetch");
        step(1'b1, 1'b0, OP_LD_A, 4'b0000, 1'b1, f_zero(4'd1), "ld_exec");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, OP_LD_A, 4'b0000, 1'b0, f_mem(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1), "ld_wait");
        step(1'b1, 1'b0, OP_LD_A, 4'b0000, 1'b1, f_mem(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 4'd1), "ld_done");

        // Status sampled in EXEC governs the jump, not the FETCH-cycle value
        run2(OP_JEQ, 4'b0000, 4'b0001, f_jmp(1'b1, 1'b0, 4'd2), 4'd2, "jeq_taken");
        run2(OP_JEQ, 4'b0001, 4'b0000, f_jmp(1'b0, 1'b1, 4'd3), 4'd3, "jeq_not");
        run2(OP_JCS, 4'b0000, 4'b0100, f_jmp(1'b1, 1'b0, 4'd4), 4'd4, "jcs_taken");
        run2(OP_JNE, 4'b0000, 4'b1110, f_jmp(1'b1, 1'b0, 4'd5), 4'd5, "jne_taken");
        run2(OP_JMI, 4'b0010, 4'b1101, f_jmp(1'b0, 1'b1, 4'd6), 4'd6, "jmi_not");
        run2(OP_JMP, 4'b0000, 4'b0000, f_jmp(1'b1, 1'b0, 4'd7), 4'd7, "jmp");

        run2(OP_BAD, 4'b0000, 4'b0000, f_ill(4'd8), 4'd8, "illegal");
        run2(OP_CMP_AB, 4'b0000, 4'b0000, f_alu(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 4'b0001, 4'd8), 4'd8, "cmp");
        run2(OP_SHR_B, 4'b0000, 4'b0000, f_alu(1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 4'b1000, 4'd9), 4'd9, "shr_b");
        run2(OP_INC_B, 4'b0000, 4'b0000, f_alu(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 4'b0000, 4'd10), 4'd10, "inc_b");
        run2(OP_OR_BA, 4'b0000, 4'b0000, f_alu(1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 4'b0011, 4'd11), 4'd11, "or_ba");
        run2(OP_AND_AK, 4'b0000, 4'b0000, f_alu(1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 4'b0010, 4'd12), 4'd12, "and_ak");

        // ST aborted by reset while waiting in MEM
        run2(OP_ST_A, 4'b0000, 4'b0000, f_zero(4'd13), 4'd13, "st");
        step(1'b1, 1'b0, OP_ST_A, 4'b0000, 1'b0, f_mem(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 4'd13), "st_wait1");
        step(1'b1, 1'b0, OP_ST_A, 4'b0000, 1'b0, f_mem(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 4'd13), "st_wait2");
        step(1'b0, 1'b1, OP_ST_A, 4'b0000, 1'b0, f_zero(4'd0), "st_reset_abort");
        step(1'b0, 1'b0, OP_ST_A, 4'b0000, 1'b1, f_zero(4'd0), "st_reset_hold");

        // 16 retirements wrap a 4-bit counter back to zero
        for (int i = 0; i < 16; i++)
            run2(OP_ADD_AB, 4'b0000, 4'b0000, f_alu(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 4'(i)), 4'(i), "add_wrap");

        run2(OP_MOV_BA, 4'b0000, 4'b0000, f_alu(1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 4'b0000, 4'd0), 4'd0, "mov_ba");
        run2(OP_HALT, 4'b0000, 4'b0000, f_zero(4'd1), 4'd1, "halt");
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, OP_ADD_AB, 4'b1111, 1'b1, f_halt(4'd1), "halted");
        step(1'b0, 1'b1, OP_ADD_AB, 4'b0000, 1'b0, f_zero(4'd0), "halt_reset");
        step(1'b1, 1'b1, OP_ADD_AB, 4'b0000, 1'b0, f_fetch(4'd0), "post_halt_fetch");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
